ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Parametrised, registered control unit for the 5-bit-opcode CPU. It decodes the ID-stage opcode into the control bundle and holds it in an ID/EX control register with stall and flush. It also contains an interrupt-entry sequencer that injects an INT pseudo-op into the pipeline and blocks nesting until RETI retires. It sits between fetch/decode and the execute/memory/writeback datapath.

## Interface
Parameters:
- OPW, 5, opcode width; opcodes occupy the low 5 bits, and any nonzero upper bit decodes as illegal
- NUM_IRQ, 4, number of interrupt lines (≥1)
- VEC_W, 16, vector address width
- VEC_BASE, 16'h0010, address of vector 0
- VEC_STRIDE, 4, byte spacing between vectors

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  opcode in ID is a real instruction
- id_opcode  in  OPW  ID-stage opcode
- stall  in  1  hold the ID/EX register
- flush  in  1  load a bubble into the ID/EX register
- irq  in  NUM_IRQ  level interrupt requests
- irq_mask  in  NUM_IRQ  1 = line enabled
- id_ready  out  1  ID opcode is consumed this cycle
- ex_valid  out  1  ID/EX slot holds an instruction
- ex_ctrl  out  CTRL_W  registered ctrl_t bundle
- irq_take  out  1  one-cycle pulse when INT is injected
- irq_id  out  $clog2(NUM_IRQ) (min 1)  accepted line, held until the next take
- irq_vec  out  VEC_W  VEC_BASE + irq_id*VEC_STRIDE, truncated to VEC_W
- in_isr  out  1  sequencer is in ISR state

## Operation
Opcode map (package constants):
- ALU group: 00xxx, 0100x
- Memory and stack: LLB 01100, LD 01101, ST 01110, PUSH 01111, POP 10000
- Control flow: B 10001, BEQ 10010, JMP 10011, FUN 10100, RET 10101, RETI 10110
- Illegal: 10111–11111
- INT is an internal pseudo-op only, never accepted from id_opcode.

Decode (combinational, then registered):
- wEn asserted for: ALU group, LLB, LD, POP, FUN, INT.
- memrd asserted for: LD, POP.
- memwr asserted for: ST, PUSH.
- SPwe asserted for: PUSH, POP.
- MemInSel asserted for: PUSH.
- Reg1Sel = memrd | memwr.
- ALU_A_SEL: 01 for PUSH/POP; 10 for FUN/INT; else 00.
- ALU_B_SEL: 01 for immediate ops (00001, 00011, 0010x, 00110, 0110x, 01110); 10 for PUSH/POP/FUN/INT; else 00.
- B, BEQ: asserted for their own opcodes.
- JMP: asserted for JMP, FUN, INT.
- RET: asserted for RET, RETI.
- WbDataSel: 11 for ALU group and LLB; 10 for LD/POP; else 00.
- WbRegSel: 00 = Rx, 01 = LR (FUN), 10 = ILR (INT).
- Reg0Sel: 10 for RET; 11 for RETI; else 01.
- imm_sel: 10 for JMP/FUN; 01 for LLB; 11 for INT (vector); else 00.
- illegal: asserted for illegal opcodes; wEn, memwr, memrd, SPwe, JMP, B, BEQ and RET are forced to 0 when it is set.

ID/EX register:
- flush: ex_valid←0 and ex_ctrl←0. flush overrides stall.
- else stall: hold the register.
- else INT injection (see below): load the INT bundle with ex_valid←1.
- else: load decode(id_opcode) with ex_valid←id_valid.
- id_ready = !stall & !flush & !inject.

Sequencer states:
- RUN → ISR when pending = irq & irq_mask is nonzero, !stall, !flush, and the EX slot holds no valid B/BEQ/JMP/FUN/RET/RETI (a redirect must not be lost).
- inject fires in that cycle: irq_take=1; irq_id←lowest-index pending line; irq_vec updated.
- ISR: no injection, regardless of irq.
- ISR → RUN when ex_valid & ex_ctrl is RETI & !stall & !flush (RETI leaves EX).
- A RETI flushed out of EX does not exit ISR.

## Timing
- Reset (async assert): ex_valid=0, ex_ctrl=0, irq_take=0, irq_id=0, irq_vec=VEC_BASE, in_isr=0, state RUN. Outputs that are a function of stall/flush follow those inputs; id_ready is 0 only if stall or flush is high.
- Latency: decode → ex_* takes 1 cycle. irq assertion → irq_take in the same cycle if eligible; INT appears in ex_* and in_isr=1 on the next edge.
- A line deasserted before acceptance is ignored; no latching of requests.
- When a stall and a pending irq occur together, injection is deferred, not dropped.
- RETI exit and a new pending irq in the same cycle: exit takes effect this cycle; injection is eligible the cycle after.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams
  - ctrl_t packed struct (all bundle fields plus illegal) and CTRL_W
  - sel encodings
  - the seq_state_t enum {RUN, ISR}
- Sub-module ctrl_decode: a pure combinational opcode→ctrl_t function, also used to build the INT bundle.

## Test plan
- Reset: hold rst_n=0 mid-stream with ex_valid=1 → all outputs read reset values asynchronously; after release, the first ID opcode 01101 gives ex_ctrl with memrd=1, WbDataSel=10.
- Decode sweep: apply all 32 opcodes → bundles match the map; 10111–11111 give illegal=1 and all enables 0.
- Stall/flush: during stall=1, ex_ctrl holds for 3 cycles and id_ready=0; assert flush and stall together → ex_valid=0 next cycle.
- Priority and injection: irq=4'b1010, mask=4'b1111 → irq_take pulse, irq_id=1, irq_vec=16'h0014; next cycle ex_ctrl shows INT with WbRegSel=10 and in_isr=1.
- No nesting: in ISR, irq=4'b0001 → no take. RETI leaves EX → in_isr=0, then a take occurs 1 cycle later with irq_id=0.
- Redirect guard: a valid JMP in EX while irq is pending → injection waits 1 cycle; a masked line (mask=0) is never taken.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcode map, control-bundle layout and select encodings for the
// 5-bit-opcode CPU control path.
package ctrl_pkg;
  localparam logic [4:0] OP_LLB  = 5'b01100;
  localparam logic [4:0] OP_LD   = 5'b01101;
  localparam logic [4:0] OP_ST   = 5'b01110;
  localparam logic [4:0] OP_PUSH = 5'b01111;
  localparam logic [4:0] OP_POP  = 5'b10000;
  localparam logic [4:0] OP_B    = 5'b10001;
  localparam logic [4:0] OP_BEQ  = 5'b10010;
  localparam logic [4:0] OP_JMP  = 5'b10011;
  localparam logic [4:0] OP_FUN  = 5'b10100;
  localparam logic [4:0] OP_RET  = 5'b10101;
  localparam logic [4:0] OP_RETI = 5'b10110;
  localparam logic [4:0] OP_ILL0 = 5'b10111;

  localparam logic [1:0] ALU_A_REG = 2'b00, ALU_A_SP  = 2'b01, ALU_A_PC    = 2'b10;
  localparam logic [1:0] ALU_B_REG = 2'b00, ALU_B_IMM = 2'b01, ALU_B_CONST = 2'b10;
  localparam logic [1:0] WB_DATA_NONE = 2'b00, WB_DATA_MEM = 2'b10, WB_DATA_ALU = 2'b11;
  localparam logic [1:0] WB_REG_RX = 2'b00, WB_REG_LR = 2'b01, WB_REG_ILR = 2'b10;
  localparam logic [1:0] REG0_RX = 2'b01, REG0_LR = 2'b10, REG0_ILR = 2'b11;
  localparam logic [1:0] IMM_NONE = 2'b00, IMM_LLB = 2'b01, IMM_JMP = 2'b10, IMM_VEC = 2'b11;

  typedef struct packed {
    logic       w_en;
    logic       mem_rd;
    logic       mem_wr;
    logic       sp_we;
    logic       mem_in_sel;
    logic       reg1_sel;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic       b;
    logic       beq;
    logic       jmp;
    logic       ret;
    logic [1:0] wb_data_sel;
    logic [1:0] wb_reg_sel;
    logic [1:0] reg0_sel;
    logic [1:0] imm_sel;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef enum logic {RUN = 1'b0, ISR = 1'b1} seq_state_t;
endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode -> control bundle decode; int_op builds the
// INT pseudo-op bundle, which has no encoding in the opcode space.
module ctrl_decode import ctrl_pkg::*; #(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  input  logic           int_op,
  output ctrl_t          ctrl
);
  logic [4:0] op;
  logic       hi_bad, alu, push_pop;

  always_comb begin
    op       = opcode[4:0];
    hi_bad   = |(opcode >> 5);
    alu      = (op[4:3] == 2'b00) || (op[4:1] == 4'b0100);
    push_pop = (op == OP_PUSH) || (op == OP_POP);
    ctrl          = '0;
    ctrl.reg0_sel = REG0_RX;
    if (int_op) begin
      ctrl.w_en       = 1'b1;
      ctrl.alu_a_sel  = ALU_A_PC;
      ctrl.alu_b_sel  = ALU_B_CONST;
      ctrl.jmp        = 1'b1;
      ctrl.wb_reg_sel = WB_REG_ILR;
      ctrl.imm_sel    = IMM_VEC;
    end else if (hi_bad || op >= OP_ILL0) begin
      // Illegal leaves every enable clear; only the flag is raised.
      ctrl.illegal = 1'b1;
    end else begin
      ctrl.w_en       = alu || op inside {OP_LLB, OP_LD, OP_POP, OP_FUN};
      ctrl.mem_rd     = op inside {OP_LD, OP_POP};
      ctrl.mem_wr     = op inside {OP_ST, OP_PUSH};
      ctrl.sp_we      = push_pop;
      ctrl.mem_in_sel = (op == OP_PUSH);
      ctrl.reg1_sel   = ctrl.mem_rd || ctrl.mem_wr;
      if (push_pop)          ctrl.alu_a_sel = ALU_A_SP;
      else if (op == OP_FUN) ctrl.alu_a_sel = ALU_A_PC;
      if (op inside {5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110, OP_LLB, OP_LD, OP_ST})
        ctrl.alu_b_sel = ALU_B_IMM;
      else if (push_pop || op == OP_FUN)
        ctrl.alu_b_sel = ALU_B_CONST;
      ctrl.b   = (op == OP_B);
      ctrl.beq = (op == OP_BEQ);
      ctrl.jmp = op inside {OP_JMP, OP_FUN};
      ctrl.ret = op inside {OP_RET, OP_RETI};
      if (alu || op == OP_LLB)             ctrl.wb_data_sel = WB_DATA_ALU;
      else if (op inside {OP_LD, OP_POP})  ctrl.wb_data_sel = WB_DATA_MEM;
      if (op == OP_FUN) ctrl.wb_reg_sel = WB_REG_LR;
      if (op == OP_RET)       ctrl.reg0_sel = REG0_LR;
      else if (op == OP_RETI) ctrl.reg0_sel = REG0_ILR;
      if (op inside {OP_JMP, OP_FUN}) ctrl.imm_sel = IMM_JMP;
      else if (op == OP_LLB)          ctrl.imm_sel = IMM_LLB;
    end
  end
endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX control register with stall/flush plus the interrupt-entry
// sequencer that injects INT and blocks nesting until RETI retires.
module ctrl_pipe import ctrl_pkg::*; #(
  parameter int                 OPW        = 5,
  parameter int                 NUM_IRQ    = 4,
  parameter int                 VEC_W      = 16,
  parameter logic [VEC_W-1:0]   VEC_BASE   = 16'h0010,
  parameter int                 VEC_STRIDE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [OPW-1:0]         id_opcode,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [NUM_IRQ-1:0]     irq,
  input  logic [NUM_IRQ-1:0]     irq_mask,
  output logic                   id_ready,
  output logic                   ex_valid,
  output logic [CTRL_W-1:0]      ex_ctrl,
  output logic                   irq_take,
  output logic [((NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1)-1:0] irq_id,
  output logic [VEC_W-1:0]       irq_vec,
  output logic                   in_isr
);
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  ctrl_t        dec_ctrl, int_ctrl, ex_q;
  seq_state_t   state;
  logic [NUM_IRQ-1:0] pending;
  logic [ID_W-1:0]    pend_id;
  logic         redirect_in_ex, reti_in_ex, inject;

  ctrl_decode #(.OPW(OPW)) u_dec (.opcode(id_opcode), .int_op(1'b0), .ctrl(dec_ctrl));
  ctrl_decode #(.OPW(OPW)) u_int (.opcode('0),        .int_op(1'b1), .ctrl(int_ctrl));

  always_comb begin
    pend_id = '0;
    for (int i = NUM_IRQ-1; i >= 0; i--)
      if (pending[i]) pend_id = ID_W'(i);
  end

  assign pending        = irq & irq_mask;
  // A redirect already in EX must reach the datapath before INT displaces it.
  assign redirect_in_ex = ex_valid && (ex_q.b || ex_q.beq || ex_q.jmp || ex_q.ret);
  assign reti_in_ex     = ex_valid && (ex_q.reg0_sel == REG0_ILR);
  assign inject         = (state == RUN) && (|pending) && !stall && !flush && !redirect_in_ex;
  assign irq_take       = inject;
  assign id_ready       = !stall && !flush && !inject;
  assign ex_ctrl        = ex_q;
  assign in_isr         = (state == ISR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
      state    <= RUN;
      irq_id   <= '0;
      irq_vec  <= VEC_BASE;
    end else begin
      if (flush) begin
        ex_valid <= 1'b0;
        ex_q     <= '0;
      end else if (!stall) begin
        ex_valid <= inject ? 1'b1 : id_valid;
        ex_q     <= inject ? int_ctrl : dec_ctrl;
      end
      if (inject) begin
        state   <= ISR;
        irq_id  <= pend_id;
        irq_vec <= VEC_BASE + VEC_W'(int'(pend_id) * VEC_STRIDE);
      end else if (state == ISR && reti_in_ex && !stall && !flush) begin
        state <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: the driver pushes expected outputs from an
// opcode-level model, a negedge monitor pops and compares.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [4:0] id_opcode = '0;
  logic [3:0] irq = '0, irq_mask = '0;
  logic id_ready, ex_valid, irq_take, in_isr;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [1:0]  irq_id;
  logic [15:0] irq_vec;

  ctrl_pipe #(.OPW(5), .NUM_IRQ(4), .VEC_W(16), .VEC_BASE(16'h0010), .VEC_STRIDE(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .stall(stall), .flush(flush), .irq(irq), .irq_mask(irq_mask),
    .id_ready(id_ready), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .irq_take(irq_take), .irq_id(irq_id), .irq_vec(irq_vec), .in_isr(in_isr));

  always #5 clk = ~clk;

  typedef struct {
    logic ready, take, valid, isr;
    logic [1:0]  id;
    logic [15:0] vec;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  // Model: m_op is the instruction sitting in EX (-1 = cleared, 32 = INT).
  bit m_valid = 0, m_isr = 0;
  int m_op = -1, m_id = 0;

  function automatic ctrl_t ref_ctrl(int op);
    ctrl_t c;
    bit alu;
    c = '0;
    if (op < 0) return c;
    c.reg0_sel = 2'd1;
    if (op == 32) begin
      c.w_en = 1; c.alu_a_sel = 2'd2; c.alu_b_sel = 2'd2; c.jmp = 1;
      c.wb_reg_sel = 2'd2; c.imm_sel = 2'd3;
      return c;
    end
    if (op >= 23) begin c.illegal = 1; return c; end
    alu = (op <= 9);
    c.w_en        = alu || (op inside {12, 13, 16, 20});
    c.mem_rd      = op inside {13, 16};
    c.mem_wr      = op inside {14, 15};
    c.sp_we       = op inside {15, 16};
    c.mem_in_sel  = (op == 15);
    c.reg1_sel    = op inside {13, 14, 15, 16};
    c.alu_a_sel   = (op inside {15, 16}) ? 2'd1 : (op == 20) ? 2'd2 : 2'd0;
    c.alu_b_sel   = (op inside {1, 3, 4, 5, 6, 12, 13, 14}) ? 2'd1 :
                    (op inside {15, 16, 20}) ? 2'd2 : 2'd0;
    c.b           = (op == 17);
    c.beq         = (op == 18);
    c.jmp         = op inside {19, 20};
    c.ret         = op inside {21, 22};
    c.wb_data_sel = (alu || op == 12) ? 2'd3 : (op inside {13, 16}) ? 2'd2 : 2'd0;
    c.wb_reg_sel  = (op == 20) ? 2'd1 : 2'd0;
    c.reg0_sel    = (op == 21) ? 2'd2 : (op == 22) ? 2'd3 : 2'd1;
    c.imm_sel     = (op inside {19, 20}) ? 2'd2 : (op == 12) ? 2'd1 : 2'd0;
    return c;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Apply inputs for the current cycle, queue what the DUT must show, step the model.
  task automatic drive(bit v, int op, bit st, bit fl, logic [3:0] rq, logic [3:0] mk);
    exp_t e;
    logic [3:0] pend;
    bit redir, inj;
    int nid;
    id_valid = v; id_opcode = 5'(op); stall = st; flush = fl; irq = rq; irq_mask = mk;
    pend  = rq & mk;
    redir = m_valid && (m_op inside {[17:22], 32});
    inj   = !m_isr && (pend != 0) && !st && !fl && !redir;
    e.ready = !st && !fl && !inj;
    e.take  = inj;
    e.valid = m_valid;
    e.isr   = m_isr;
    e.id    = 2'(m_id);
    e.vec   = 16'(16 + 4 * m_id);
    e.ctrl  = ref_ctrl(m_op);
    q.push_back(e);
    if (m_isr && m_valid && m_op == 22 && !st && !fl) m_isr = 0;
    if (inj) begin
      nid = 0;
      for (int i = 3; i >= 0; i--) if (pend[i]) nid = i;
      m_id = nid; m_isr = 1;
    end
    if (fl) begin m_valid = 0; m_op = -1; end
    else if (!st) begin
      if (inj) begin m_valid = 1; m_op = 32; end
      else begin m_valid = v; m_op = op; end
    end
  endtask

  task automatic cyc(bit v, int op, bit st, bit fl, logic [3:0] rq, logic [3:0] mk);
    @(posedge clk); #1;
    drive(v, op, st, fl, rq, mk);
  endtask

  task automatic model_reset();
    m_valid = 0; m_isr = 0; m_op = -1; m_id = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        chk("id_ready", 32'(id_ready), 32'(e.ready));
        chk("irq_take", 32'(irq_take), 32'(e.take));
        chk("ex_valid", 32'(ex_valid), 32'(e.valid));
        chk("ex_ctrl",  32'(ex_ctrl),  32'(e.ctrl));
        chk("in_isr",   32'(in_isr),   32'(e.isr));
        chk("irq_id",   32'(irq_id),   32'(e.id));
        chk("irq_vec",  32'(irq_vec),  32'(e.vec));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 13, 0, 0, 4'h0, 4'h0);          // first op after reset: LD
    for (int op = 0; op < 32; op++) cyc(1, op, 0, 0, 4'h0, 4'h0);

    // Mid-stream async reset with a valid instruction in EX.
    cyc(1, 3, 0, 0, 4'h0, 4'h0);
    @(posedge clk); #2;
    chk("pre_rst_ex_valid", 32'(ex_valid), 32'd1);
    rst_n = 1'b0; #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_ctrl",  32'(ex_ctrl),  32'd0);
    chk("rst_irq_take", 32'(irq_take), 32'd0);
    chk("rst_irq_id",   32'(irq_id),   32'd0);
    chk("rst_irq_vec",  32'(irq_vec),  32'h10);
    chk("rst_in_isr",   32'(in_isr),   32'd0);
    chk("rst_id_ready", 32'(id_ready), 32'd1);
    q.delete();
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    drive(1, 13, 0, 0, 4'h0, 4'h0);

    // Stall holds for three cycles; stall+flush clears.
    cyc(1, 2, 0, 0, 4'h0, 4'h0);
    repeat (3) cyc(1, 15, 1, 0, 4'h0, 4'h0);
    cyc(1, 15, 1, 1, 4'h0, 4'h0);
    cyc(0, 0, 0, 0, 4'h0, 4'h0);

    // Injection priority, no nesting, RETI exit, re-entry.
    cyc(1, 0, 0, 0, 4'b1010, 4'hF);
    cyc(1, 0, 0, 0, 4'b0001, 4'hF);
    cyc(1, 22, 0, 0, 4'b0001, 4'hF);
    cyc(1, 0, 0, 0, 4'b0001, 4'hF);
    cyc(1, 0, 0, 0, 4'b0001, 4'hF);
    // Redirect guard and masked line.
    cyc(1, 22, 0, 0, 4'h0, 4'hF);
    cyc(1, 0, 0, 0, 4'b0100, 4'b1011);
    cyc(1, 19, 0, 0, 4'b0100, 4'b1011);
    cyc(1, 0, 0, 0, 4'b0010, 4'hF);
    cyc(1, 0, 0, 0, 4'b0010, 4'hF);
    // Stall with pending irq defers injection.
    cyc(1, 22, 0, 0, 4'h0, 4'hF);
    cyc(1, 0, 0, 0, 4'h0, 4'hF);
    cyc(1, 0, 1, 0, 4'b1000, 4'hF);
    cyc(1, 0, 0, 0, 4'b1000, 4'hF);

    for (int n = 0; n < 3000; n++)
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 4'($urandom));

    cyc(0, 0, 0, 0, 4'h0, 4'h0);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
